// File: rtl/pc_reg.sv
// Program counter register: synchronous active-high reset, write-enabled load,
// hold on stall. PC_out is the register itself, with no bypass from the inputs.
module pc_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_in,
    input  logic [WIDTH-1:0] PC_in,
    output logic [WIDTH-1:0] PC_out
);

    logic [WIDTH-1:0] pc_q;

    // Reset beats write, and write beats hold. While stalled, PC_in is not
    // sampled, so X on it cannot reach the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VALUE;
        end else if (write_in) begin
            pc_q <= PC_in;
        end
    end

    assign PC_out = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: reset, hold, write, priority, glitch immunity
// and full-width sequences. Expected values are hand-computed constants.
module tb_pc_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             write_in;
    logic [WIDTH-1:0] PC_in;
    logic [WIDTH-1:0] PC_out;

    int checks = 0;
    int errors = 0;

    pc_reg #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .write_in(write_in),
        .PC_in   (PC_in),
        .PC_out  (PC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; write_in = 1'b1; PC_in = 32'h0000_0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (PC_out !== 32'h0000_0000) begin
                errors++;
                $display("FAIL reset_edge%0d: got %h expected %h", i, PC_out, 32'h0000_0000);
            end
        end
    endtask

    task automatic test_hold();
        rst = 1'b0; write_in = 1'b0; PC_in = 32'h0000_0000;
        tick();
        PC_in = 32'h0000_0100;
        tick();
        checks++;
        if (PC_out !== 32'h0000_0000) begin
            errors++;
            $display("FAIL hold_after_reset: got %h expected %h", PC_out, 32'h0000_0000);
        end
    endtask

    task automatic test_write();
        write_in = 1'b1; PC_in = 32'h0000_0100;
        #1;
        checks++;
        if (PC_out !== 32'h0000_0000) begin
            errors++;
            $display("FAIL write_no_comb_path: got %h expected %h", PC_out, 32'h0000_0000);
        end
        tick();
        checks++;
        if (PC_out !== 32'h0000_0100) begin
            errors++;
            $display("FAIL write_load: got %h expected %h", PC_out, 32'h0000_0100);
        end
        write_in = 1'b0; PC_in = 32'h0000_0200;
        tick();
        tick();
        checks++;
        if (PC_out !== 32'h0000_0100) begin
            errors++;
            $display("FAIL write_then_stall: got %h expected %h", PC_out, 32'h0000_0100);
        end
    endtask

    task automatic test_reset_override();
        rst = 1'b1; write_in = 1'b1; PC_in = 32'h0000_0200;
        #1;
        checks++;
        if (PC_out !== 32'h0000_0100) begin
            errors++;
            $display("FAIL reset_is_sync: got %h expected %h", PC_out, 32'h0000_0100);
        end
        tick();
        checks++;
        if (PC_out !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_beats_write: got %h expected %h", PC_out, 32'h0000_0000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (PC_out !== 32'h0000_0200) begin
            errors++;
            $display("FAIL write_after_reset: got %h expected %h", PC_out, 32'h0000_0200);
        end
    endtask

    task automatic test_reset_glitch();
        write_in = 1'b0; PC_in = 32'h0000_0300;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (PC_out !== 32'h0000_0200) begin
            errors++;
            $display("FAIL glitch_between_edges: got %h expected %h", PC_out, 32'h0000_0200);
        end
        tick();
        checks++;
        if (PC_out !== 32'h0000_0200) begin
            errors++;
            $display("FAIL glitch_next_edge: got %h expected %h", PC_out, 32'h0000_0200);
        end
    endtask

    task automatic test_sequence();
        logic [WIDTH-1:0] seq [4];
        seq[0] = 32'h0000_0000;
        seq[1] = 32'h0000_0004;
        seq[2] = 32'h0000_0008;
        seq[3] = 32'hFFFF_FFFC;
        write_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PC_in = seq[i];
            tick();
            checks++;
            if (PC_out !== seq[i]) begin
                errors++;
                $display("FAIL sequence_step%0d: got %h expected %h", i, PC_out, seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 32'hDEAD_BEEF;
        vals[1] = 32'h8000_0001;
        vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h1234_5673;
        write_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PC_in = vals[i];
            tick();
            checks++;
            if (PC_out !== vals[i]) begin
                errors++;
                $display("FAIL back_to_back%0d: got %h expected %h", i, PC_out, vals[i]);
            end
        end
    endtask

    task automatic test_xz_hold();
        write_in = 1'b0;
        PC_in = 'x;
        tick();
        PC_in = 'z;
        tick();
        checks++;
        if (PC_out !== 32'h1234_5673) begin
            errors++;
            $display("FAIL xz_hold: got %h expected %h", PC_out, 32'h1234_5673);
        end
        rst = 1'b1; PC_in = 32'h0000_0040;
        tick();
        checks++;
        if (PC_out !== 32'h0000_0000) begin
            errors++;
            $display("FAIL final_reset: got %h expected %h", PC_out, 32'h0000_0000);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write_in = 1'b0; PC_in = '0;
        #2;
        test_reset();
        test_hold();
        test_write();
        test_reset_override();
        test_reset_glitch();
        test_sequence();
        test_back_to_back();
        test_xz_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 Parameter: WIDTH, default 32, PC data width in bits.
REQ-002 Parameter: RESET_VALUE, default 32'h0000_0000, value loaded into PC on reset; WIDTH bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: write_in  input  1  PC write enable; 1 = load PC_in, 0 = hold (pipeline stall).
REQ-006 Port: PC_in  input  WIDTH  next program counter value.
REQ-007 Port: PC_out  output  WIDTH  current program counter, driven directly from the internal register.
REQ-008 The module SHALL have one clock domain and no other ports.

Function
REQ-009 PC_out SHALL be a registered output with no combinational path from PC_in, write_in or rst.
REQ-010 On a rising clk edge with rst=1, the register SHALL load RESET_VALUE, regardless of write_in and PC_in.
REQ-011 On a rising clk edge with rst=0 and write_in=1, the register SHALL load PC_in; PC_out SHALL show it after that edge (1-cycle latency).
REQ-012 On a rising clk edge with rst=0 and write_in=0, the register SHALL hold its value; changes on PC_in SHALL be ignored.
REQ-013 Priority SHALL be rst > write_in > hold.
REQ-014 The full WIDTH-bit value SHALL be stored unmodified: no alignment masking, increment or truncation.
REQ-015 write_in=1 held for several cycles SHALL reload PC_in on every edge, so PC_out follows PC_in one cycle late.
REQ-016 rst asserted mid-operation SHALL override any pending write on that edge; the next edge after rst deasserts SHALL follow REQ-011/REQ-012.
REQ-017 X/Z on PC_in with write_in=0 SHALL NOT corrupt the held value.

Reset
REQ-018 Reset SHALL be synchronous: asserting rst between edges SHALL NOT change PC_out until the next rising clk edge.
REQ-019 After any reset edge, PC_out SHALL equal RESET_VALUE (0x00000000 by default).
REQ-020 Before the first clk edge with rst=1, PC_out is undefined; benches SHALL NOT check it.

Verification
REQ-021 rst=1 for 2 edges, PC_in=0x100, write_in=1 -> PC_out=0x00000000 after each edge.
REQ-022 rst=0, write_in=0, PC_in changes 0x0->0x100 -> PC_out holds its previous value (0x0).
REQ-023 rst=0, write_in=1, PC_in=0x100 -> PC_out=0x00000100 after the next edge; then write_in=0, PC_in=0x200 -> PC_out stays 0x100.
REQ-024 PC_out=0x100, rst=1 for one edge with write_in=1, PC_in=0x200 -> PC_out=0x0; rst=0 next edge -> PC_out=0x200.
REQ-025 rst pulsed high and low again between two clk edges -> PC_out unchanged.
REQ-026 write_in=1 with PC_in stepping 0x0, 0x4, 0x8, 0xFFFFFFFC -> PC_out shows the same sequence one cycle late, including the all-high value.
